pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of period/duty/counter fields.
REQ-002 SHALL have parameter DIV, default 1: clocks per PWM tick, legal range >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cfg_valid  input  1  config request.
REQ-006 SHALL have port cfg_ready  output  1  holding register empty; config accepted when cfg_valid && cfg_ready.
REQ-007 SHALL have port cfg_mode  input  2  0=level low, 1=level high, 2=continuous PWM, 3=single pulse.
REQ-008 SHALL have port cfg_period  input  CNT_W  PWM period in ticks.
REQ-009 SHALL have port cfg_duty  input  CNT_W  high time in ticks (PWM and pulse modes).
REQ-010 SHALL have port pwm_out  output  1  registered PWM/level output.
REQ-011 SHALL have port period_start  output  1  one-clock strobe on the first clock of each PWM period and of a single pulse.
REQ-012 SHALL have port busy  output  1  high while a single pulse is in progress.

Function
REQ-013 SHALL hold one pending config (holding register) and one active config; cfg_ready = holding register empty.
REQ-014 SHALL use states IDLE_LEVEL (modes 0/1), RUN_PWM (mode 2), PULSE_HIGH and PULSE_DONE (mode 3).
REQ-015 In IDLE_LEVEL or PULSE_DONE, SHALL transfer the pending config to active on the clock after acceptance; holding register stays empty, so cfg_ready remains high.
REQ-016 In RUN_PWM, SHALL transfer the pending config only at the period boundary (tick counter wrapping to 0); cfg_ready low from acceptance until that transfer.
REQ-017 In PULSE_HIGH, SHALL transfer the pending config only after the pulse ends; cfg_ready low meanwhile.
REQ-018 On loading an active config, SHALL clear the tick counter and the prescaler to 0.
REQ-019 SHALL advance the tick counter once every DIV clocks; the counter counts 0..period-1 then wraps to 0.
REQ-020 SHALL, in RUN_PWM, drive pwm_out high for exactly duty*DIV clocks, then low for (period-duty)*DIV clocks, repeating.
REQ-021 SHALL raise pwm_out for the first period on the clock edge that loads the active config, i.e. 1 clock after the handshake from IDLE_LEVEL.
REQ-022 Mode 2 with duty = 0 or period = 0 SHALL hold pwm_out low; mode 2 with duty >= period (period > 0) SHALL hold pwm_out high; period_start still pulses each period when period > 0.
REQ-023 Mode 3 SHALL drive one high pulse of duty*DIV clocks, then enter PULSE_DONE with pwm_out low; duty = 0 SHALL produce no pulse and go straight to PULSE_DONE; cfg_period ignored.
REQ-024 SHALL hold busy high exactly for the clocks pwm_out is high in PULSE_HIGH.
REQ-025 Modes 0/1 SHALL drive pwm_out constant 0/1 from the loading edge; period_start stays 0.
REQ-026 A handshake on the same clock as a period boundary SHALL NOT be applied at that boundary; it applies at the next boundary.
REQ-027 Counter compare SHALL be unsigned CNT_W-bit; no overflow for period = 2^CNT_W-1.

Reset
REQ-028 While rst_n = 0 at a clock edge: pwm_out=0, period_start=0, busy=0, cfg_ready=0, state IDLE_LEVEL (mode 0), counter/prescaler/holding cleared.
REQ-029 SHALL raise cfg_ready on the first clock edge with rst_n = 1.
REQ-030 Reset asserted mid-period or mid-pulse SHALL abort immediately, discarding both the active and the pending config.

Verification
REQ-031 CNT_W=8, DIV=1: mode 2, period 10, duty 3 -> pwm_out high 3 clocks / low 7, repeating; period_start every 10 clocks; measured duty 30%.
REQ-032 Running period 10 duty 3, new config duty 5 accepted mid-period -> cfg_ready low until the boundary; the next period is high 5 / low 5.
REQ-033 DIV=4: mode 3, duty 4 -> single 16-clock high pulse, busy high the same 16 clocks, then pwm_out low indefinitely.
REQ-034 mode 2, period 10, duty 0 -> pwm_out constant 0; duty 12 -> constant 1; period_start every 10 clocks in both.
REQ-035 Modes 1 then 0 -> pwm_out 1 then 0, each 1 clock after its handshake, stable for 1000 clocks with no glitch.
REQ-036 rst_n low for 1 clock mid-PWM-high -> pwm_out=0 and cfg_ready=0 on that edge; cfg_ready=1 one clock later; pwm_out stays 0 until a new config.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM / level / single-pulse generator with a one-deep config holding register.
// Pending configs are applied immediately when idle, at period boundaries when running.
module pwm_gen #(
  parameter int CNT_W = 16,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LEVEL = 2'd0,
    RUN_PWM    = 2'd1,
    PULSE_HIGH = 2'd2,
    PULSE_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               level_q, level_d;
  logic [CNT_W-1:0]   per_q, per_d, duty_q, duty_d, cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               hold_vld_q, hold_vld_d;
  logic [1:0]         hold_mode_q, hold_mode_d;
  logic [CNT_W-1:0]   hold_per_q, hold_per_d, hold_duty_q, hold_duty_d;
  logic               pwm_q, pwm_d, start_q, start_d, busy_q, busy_d, ready_q, ready_d;
  logic               accept_s, tick_s, wrap_s, pulse_end_s, load_s, start_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE_LEVEL;
    else        state_q <= state_d;
  end

  always_comb begin
    accept_s    = cfg_valid && ready_q;
    tick_s      = (pre_q == PRE_MAX);
    // period 0 has no real wrap; treat every tick as a boundary so a pending config can still land
    wrap_s      = tick_s && ((per_q == ZERO) || (cnt_q == per_q - ONE));
    pulse_end_s = tick_s && (cnt_q == duty_q - ONE);
    case (state_q)
      IDLE_LEVEL, PULSE_DONE: load_s = hold_vld_q;
      RUN_PWM:                load_s = hold_vld_q && wrap_s;
      default:                load_s = 1'b0;
    endcase
    state_d = state_q;
    level_d = level_q;
    per_d   = per_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    pre_d   = tick_s ? PRE_ZERO : pre_q + PRE_ONE;
    start_s = 1'b0;
    if (load_s) begin
      per_d  = hold_per_q;
      duty_d = hold_duty_q;
      cnt_d  = ZERO;
      pre_d  = PRE_ZERO;
      case (hold_mode_q)
        2'd0, 2'd1: begin
          state_d = IDLE_LEVEL;
          level_d = hold_mode_q[0];
        end
        2'd2: begin
          state_d = RUN_PWM;
          start_s = (hold_per_q != ZERO);
        end
        default: begin
          state_d = (hold_duty_q != ZERO) ? PULSE_HIGH : PULSE_DONE;
          start_s = (hold_duty_q != ZERO);
        end
      endcase
    end else if (state_q == RUN_PWM) begin
      cnt_d   = tick_s ? (wrap_s ? ZERO : cnt_q + ONE) : cnt_q;
      start_s = wrap_s && (per_q != ZERO);
    end else if (state_q == PULSE_HIGH) begin
      state_d = pulse_end_s ? PULSE_DONE : PULSE_HIGH;
      cnt_d   = pulse_end_s ? ZERO : (tick_s ? cnt_q + ONE : cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
    hold_vld_d  = accept_s ? 1'b1 : (load_s ? 1'b0 : hold_vld_q);
    hold_mode_d = accept_s ? cfg_mode   : hold_mode_q;
    hold_per_d  = accept_s ? cfg_period : hold_per_q;
    hold_duty_d = accept_s ? cfg_duty   : hold_duty_q;
  end

  always_comb begin
    case (state_d)
      IDLE_LEVEL: pwm_d = level_d;
      RUN_PWM:    pwm_d = (per_d != ZERO) && (cnt_d < duty_d);
      PULSE_HIGH: pwm_d = 1'b1;
      default:    pwm_d = 1'b0;
    endcase
    busy_d  = (state_d == PULSE_HIGH);
    start_d = start_s;
    // idle states drain the holding register on the very next clock, so they never stall the handshake
    ready_d = !hold_vld_d || (state_d == IDLE_LEVEL) || (state_d == PULSE_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q     <= 1'b0;
      per_q       <= ZERO;
      duty_q      <= ZERO;
      cnt_q       <= ZERO;
      pre_q       <= PRE_ZERO;
      hold_vld_q  <= 1'b0;
      hold_mode_q <= 2'd0;
      hold_per_q  <= ZERO;
      hold_duty_q <= ZERO;
      pwm_q       <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      per_q       <= per_d;
      duty_q      <= duty_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      hold_vld_q  <= hold_vld_d;
      hold_mode_q <= hold_mode_d;
      hold_per_q  <= hold_per_d;
      hold_duty_q <= hold_duty_d;
      pwm_q       <= pwm_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign busy         = busy_q;
  assign cfg_ready    = ready_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: two instances (DIV=1 and DIV=4) checked every clock against a
// timeline model that derives outputs from the clock count since the config was loaded.
module tb_pwm_gen;

  localparam int W = 8;
  localparam int ST_LEVEL = 0, ST_RUN = 1, ST_PULSE = 2, ST_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rstn_s, vld_s, rdy_s, pwm_s, ps_s, bsy_s;
  logic [1:0]   mode_s [2];
  logic [W-1:0] per_s  [2];
  logic [W-1:0] duty_s [2];

  pwm_gen #(.CNT_W(W), .DIV(1)) u_dut_div1 (
    .clk(clk), .rst_n(rstn_s[0]), .cfg_valid(vld_s[0]), .cfg_ready(rdy_s[0]),
    .cfg_mode(mode_s[0]), .cfg_period(per_s[0]), .cfg_duty(duty_s[0]),
    .pwm_out(pwm_s[0]), .period_start(ps_s[0]), .busy(bsy_s[0]));

  pwm_gen #(.CNT_W(W), .DIV(4)) u_dut_div4 (
    .clk(clk), .rst_n(rstn_s[1]), .cfg_valid(vld_s[1]), .cfg_ready(rdy_s[1]),
    .cfg_mode(mode_s[1]), .cfg_period(per_s[1]), .cfg_duty(duty_s[1]),
    .pwm_out(pwm_s[1]), .period_start(ps_s[1]), .busy(bsy_s[1]));

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state per instance
  int m_st [2], m_age [2], m_per [2], m_duty [2], m_lvl [2];
  int h_vld [2], h_mode [2], h_per [2], h_duty [2];
  logic e_pwm [2], e_ps [2], e_bsy [2], e_rdy [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_step(input int i);
    int a, len, xfer, ps, dv;
    dv = div_of(i);
    if (!rstn_s[i]) begin
      m_st[i] = ST_LEVEL; m_lvl[i] = 0; h_vld[i] = 0; m_age[i] = 0;
      e_pwm[i] = 1'b0; e_ps[i] = 1'b0; e_bsy[i] = 1'b0; e_rdy[i] = 1'b0;
      return;
    end
    xfer = 0;
    ps   = 0;
    a    = m_age[i] + 1;
    case (m_st[i])
      ST_RUN: begin
        len = (m_per[i] == 0) ? dv : m_per[i] * dv;
        m_age[i] = a;
        if (a % len == 0) begin
          xfer = h_vld[i];
          ps   = (m_per[i] != 0) ? 1 : 0;
        end
      end
      ST_PULSE: begin
        m_age[i] = a;
        if (a == m_duty[i] * dv) m_st[i] = ST_DONE;
      end
      default: xfer = h_vld[i];
    endcase
    if (xfer != 0) begin
      m_per[i] = h_per[i]; m_duty[i] = h_duty[i]; m_age[i] = 0;
      case (h_mode[i])
        0, 1: begin m_st[i] = ST_LEVEL; m_lvl[i] = h_mode[i]; ps = 0; end
        2:    begin m_st[i] = ST_RUN; ps = (h_per[i] != 0) ? 1 : 0; end
        default: begin
          m_st[i] = (h_duty[i] != 0) ? ST_PULSE : ST_DONE;
          ps = (h_duty[i] != 0) ? 1 : 0;
        end
      endcase
    end
    if (vld_s[i] && e_rdy[i]) begin
      h_vld[i] = 1; h_mode[i] = mode_s[i]; h_per[i] = per_s[i]; h_duty[i] = duty_s[i];
    end else if (xfer != 0) begin
      h_vld[i] = 0;
    end
    case (m_st[i])
      ST_LEVEL: e_pwm[i] = (m_lvl[i] != 0);
      ST_RUN:   e_pwm[i] = (m_per[i] != 0) && (((m_age[i] / dv) % m_per[i]) < m_duty[i]);
      ST_PULSE: e_pwm[i] = 1'b1;
      default:  e_pwm[i] = 1'b0;
    endcase
    e_ps[i]  = (ps != 0);
    e_bsy[i] = (m_st[i] == ST_PULSE);
    e_rdy[i] = (h_vld[i] == 0) || (m_st[i] == ST_LEVEL) || (m_st[i] == ST_DONE);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("pwm_out[%0d]", i), pwm_s[i], e_pwm[i]);
      check_val($sformatf("period_start[%0d]", i), ps_s[i], e_ps[i]);
      check_val($sformatf("busy[%0d]", i), bsy_s[i], e_bsy[i]);
      check_val($sformatf("cfg_ready[%0d]", i), rdy_s[i], e_rdy[i]);
    end
  endtask

  task automatic send(input int i, input int mode, input int per, input int duty);
    logic ok;
    ok = 1'b0;
    vld_s[i] = 1'b1; mode_s[i] = 2'(mode); per_s[i] = W'(per); duty_s[i] = W'(duty);
    for (int k = 0; k < 3000; k++) begin
      ok = rdy_s[i];
      cycle();
      if (ok) break;
    end
    vld_s[i] = 1'b0;
    check_val($sformatf("handshake[%0d]", i), ok, 1'b1);
  endtask

  task automatic wait_ready(input int i);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (rdy_s[i]) begin ok = 1'b1; break; end
      cycle();
    end
    check_val($sformatf("ready_wait[%0d]", i), ok, 1'b1);
  endtask

  task automatic run_count(input int i, input int n, output int hi, output int ps, output int bz);
    hi = 0; ps = 0; bz = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      hi += int'(pwm_s[i] === 1'b1);
      ps += int'(ps_s[i] === 1'b1);
      bz += int'(bsy_s[i] === 1'b1);
    end
  endtask

  task automatic pulse_reset(input int i);
    rstn_s[i] = 1'b0;
    cycle();
    rstn_s[i] = 1'b1;
  endtask

  initial begin
    int hi, ps, bz;
    rstn_s = 2'b00; vld_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mode_s[i] = 2'd0; per_s[i] = '0; duty_s[i] = '0;
      m_st[i] = ST_LEVEL; m_age[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_lvl[i] = 0;
      h_vld[i] = 0; h_mode[i] = 0; h_per[i] = 0; h_duty[i] = 0;
      e_rdy[i] = 1'b0;
    end
    repeat (3) cycle();
    rstn_s = 2'b11;
    cycle();

    // period 10 duty 3: 10 full periods starting at the load edge
    send(0, 2, 10, 3);
    run_count(0, 100, hi, ps, bz);
    check_val("duty30_high", hi, 30);
    check_val("duty30_starts", ps, 10);

    // mid-period update waits for the boundary
    repeat (4) cycle();
    send(0, 2, 10, 5);
    check_val("pending_ready_low", rdy_s[0], 1'b0);
    wait_ready(0);
    run_count(0, 10, hi, ps, bz);
    check_val("duty50_high", hi, 5);

    send(0, 2, 10, 0);
    wait_ready(0);
    run_count(0, 30, hi, ps, bz);
    check_val("duty0_high", hi, 0);
    check_val("duty0_starts", ps, 3);
    send(0, 2, 10, 12);
    wait_ready(0);
    run_count(0, 30, hi, ps, bz);
    check_val("duty_over_high", hi, 30);
    check_val("duty_over_starts", ps, 3);

    // static levels
    send(0, 1, 0, 0);
    wait_ready(0);
    run_count(0, 1000, hi, ps, bz);
    check_val("level1_high", hi, 1000);
    send(0, 0, 0, 0);
    run_count(0, 1000, hi, ps, bz);
    check_val("level0_high", hi, 0);
    check_val("level0_starts", ps, 0);

    // single pulse on the DIV=4 instance
    send(1, 3, 77, 4);
    run_count(1, 40, hi, ps, bz);
    check_val("pulse_high", hi, 16);
    check_val("pulse_busy", bz, 16);
    check_val("pulse_starts", ps, 1);

    // reset mid-high aborts the active config
    send(0, 2, 10, 5);
    repeat (2) cycle();
    rstn_s[0] = 1'b0;
    cycle();
    check_val("rst_pwm", pwm_s[0], 1'b0);
    check_val("rst_ready", rdy_s[0], 1'b0);
    rstn_s[0] = 1'b1;
    cycle();
    check_val("rst_ready_back", rdy_s[0], 1'b1);
    run_count(0, 20, hi, ps, bz);
    check_val("rst_pwm_stays_low", hi, 0);

    // period 0 holds low with no strobes
    send(0, 2, 0, 3);
    run_count(0, 20, hi, ps, bz);
    check_val("per0_high", hi, 0);
    check_val("per0_starts", ps, 0);
    pulse_reset(0);
    cycle();

    // widest period without counter overflow
    send(0, 2, 255, 254);
    run_count(0, 600, hi, ps, bz);
    check_val("per255_high", hi, 598);
    check_val("per255_starts", ps, 3);
    pulse_reset(0);

    // randomized traffic on both instances
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        rstn_s[i] = ($urandom_range(0, 299) != 0);
        vld_s[i]  = ($urandom_range(0, 3) == 0);
        mode_s[i] = 2'($urandom_range(0, 3));
        per_s[i]  = ($urandom_range(0, 19) == 0) ? W'(0) : W'($urandom_range(1, 16));
        duty_s[i] = W'($urandom_range(0, 18));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
